// File: rtl/rx_uart.sv
// rx_uart -- oversampling UART receiver.
//
// Receives frames made of a start bit (0), INPUT_DATA_WIDTH data bits sent
// LSB first, an optional parity bit, and one stop bit (1). The received word
// is presented as {parity, data}, which is the same packing the companion
// transmitter consumes, so a looped-back word comes back bit-identical.
//
// Parameters
//   INPUT_DATA_WIDTH  data bits per frame
//   PARITY_ENABLED    1 = one parity bit follows the data bits, 0 = none
//   OVERSAMPLE        sample_tick pulses per bit period (even, >= 4)
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         asynchronous active-low reset
//   sample_tick   one-clk enable, OVERSAMPLE pulses per bit period
//   serial_in     asynchronous serial line, idle high
//   o_data        received {parity, data}, held until the next frame completes
//   o_valid       one-clk pulse: o_data and the error flags were just updated
//   o_parity_err  even-parity mismatch on the frame flagged by o_valid
//   o_frame_err   stop bit sampled low on the frame flagged by o_valid
//   o_busy        high from start-edge detection until return to IDLE
//
// Build option
//   RX_PARITY_CHECK_EN  when defined, o_parity_err reports an even-parity
//                       mismatch over data and parity bits; when undefined the
//                       flag is held at 0 and no check logic is built. The
//                       parity bit is captured into o_data either way.

module rx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int OVERSAMPLE       = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       sample_tick,
  input  logic                                       serial_in,
  output logic [INPUT_DATA_WIDTH+PARITY_ENABLED-1:0] o_data,
  output logic                                       o_valid,
  output logic                                       o_parity_err,
  output logic                                       o_frame_err,
  output logic                                       o_busy
);

  localparam int FRAME_BITS = INPUT_DATA_WIDTH + PARITY_ENABLED;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);

  // Counters compare against "last tick" values so that the sample happens on
  // the tick that completes the count, not one tick later.
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                  state_reg;
  logic                    sync_0_reg;
  logic                    rx_s;
  logic                    rx_prev_reg;
  logic [TICK_W-1:0]       tick_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [FRAME_BITS-1:0]   shift_reg;

  // Two-flop synchronizer plus one flop of history for falling-edge detect.
  // Reset to the idle-high level so leaving reset never looks like a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_0_reg  <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_0_reg  <= serial_in;
      rx_s        <= sync_0_reg;
      rx_prev_reg <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Edges are only looked for here, so a fall seen during STOP or
          // WAIT_IDLE has already been absorbed into rx_prev_reg.
          if (!rx_s && rx_prev_reg) begin
            state_reg    <= START;
            tick_cnt_reg <= '0;
            o_busy       <= 1'b1;
          end
        end

        START: begin
          if (sample_tick) begin
            if (tick_cnt_reg == HALF_LAST) begin
              tick_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              if (!rx_s) begin
                state_reg <= DATA;
              end else begin
                // Glitch shorter than half a bit: not a real start.
                state_reg <= IDLE;
                o_busy    <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
            end
          end
        end

        DATA: begin
          if (sample_tick) begin
            if (tick_cnt_reg == FULL_LAST) begin
              tick_cnt_reg <= '0;
              // Line order is LSB first, so entering from the top leaves the
              // first bit at index 0 once all FRAME_BITS have arrived.
              shift_reg <= {rx_s, shift_reg[FRAME_BITS-1:1]};
              if (bit_cnt_reg == BIT_LAST) begin
                bit_cnt_reg <= '0;
                state_reg   <= STOP;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
            end
          end
        end

        STOP: begin
          if (sample_tick) begin
            if (tick_cnt_reg == FULL_LAST) begin
              tick_cnt_reg <= '0;
              o_data       <= shift_reg;
              o_valid      <= 1'b1;
              o_frame_err  <= !rx_s;
`ifdef RX_PARITY_CHECK_EN
              o_parity_err <= (PARITY_ENABLED != 0) ? (^shift_reg) : 1'b0;
`else
              o_parity_err <= 1'b0;
`endif
              if (rx_s) begin
                state_reg <= IDLE;
                o_busy    <= 1'b0;
              end else begin
                // Line is in a break; wait for it to recover before looking
                // for the next start edge.
                state_reg <= WAIT_IDLE;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
            end
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state_reg <= IDLE;
            o_busy    <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
